wb_g18_arb: RTL and testbench
=============================

WB_G18_ARB -- requirements
Module: wb_g18_arb

Interface
REQ-001 Parameter wb_dw, default 32, data width of all Wishbone ports.
REQ-002 Parameter wb_aw, default 32, address width of all Wishbone ports.
REQ-003 Parameter timeout_cycles, default 64, cycles the slave may take to ack before an error is returned; legal range 2..255.
REQ-004 wb_clk_i  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 wb_rstn_i  input  1  reset, synchronous, active-low.
REQ-006 mN_adr_i/dat_i/sel_i/we_i/bte_i/cti_i/cyc_i/stb_i  input  wb_aw/wb_dw/4/1/2/3/1/1  master N Wishbone request, N=0,1.
REQ-007 mN_ack_o, mN_err_o  output  1 each  master N termination, N=0,1.
REQ-008 mN_dat_o  output  wb_dw  master N read data, N=0,1.
REQ-009 s_adr_o/dat_o/sel_o/we_o/bte_o/cti_o/cyc_o/stb_o  output  wb_aw/wb_dw/4/1/2/3/1/1  request to the flash read slave.
REQ-010 s_ack_i, s_err_i  input  1 each  slave termination.
REQ-011 s_dat_i  input  wb_dw  slave read data.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and ERR; owner SHALL be a 1-bit register naming the granted master.
REQ-013 In IDLE, with request_N = mN_cyc_i & mN_stb_i, a single request SHALL be granted; for simultaneous requests, the master not granted last (rr_ptr) SHALL win.
REQ-014 On grant: if the winner's we_i=1, next state ERR; otherwise next state BUSY; owner SHALL be updated and rr_ptr SHALL point to the other master.
REQ-015 s_cyc_o and s_stb_o SHALL be 1 only in BUSY and only while the owner holds cyc_i & stb_i; all other s_* request outputs SHALL mux combinationally from the owner.
REQ-016 mN_ack_o SHALL equal s_ack_i in BUSY when owner==N, else 0; mN_dat_o SHALL equal s_dat_i for both masters.
REQ-017 s_err_i in BUSY SHALL be forwarded to the owner's err_o under the same gating as ack.
REQ-018 On s_ack_i or s_err_i in BUSY, next state SHALL be IDLE, giving at least one cycle of s_cyc_o=0 between transfers, which the slave needs to detect a new cycle.
REQ-019 Grant-to-s_stb_o latency SHALL be 1 cycle: request seen in IDLE at cycle t, s_stb_o=1 at t+1.
REQ-020 If the owner drops cyc_i in BUSY, s_cyc_o SHALL drop in the same cycle, next state SHALL be IDLE, and no ack SHALL be forwarded.
REQ-021 ERR SHALL last exactly one cycle, with mN_err_o=1 for the owner only and s_cyc_o=0, then return to IDLE.
REQ-022 A master's ack_o and err_o SHALL never both be 1, and the non-owner SHALL never see ack_o or err_o.

Reset
REQ-023 While wb_rstn_i=0 at a clock edge: state IDLE, owner 0, rr_ptr favours m0, timeout counter 0.
REQ-024 All ack/err outputs and s_cyc_o/s_stb_o SHALL be 0 during reset; reset mid-transfer SHALL abandon the transfer with no termination.

Configuration
REQ-025 With macro WB_G18_ARB_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-026 With WB_G18_ARB_TIMEOUT_EN defined and the counter at timeout_cycles-1 with no slave ack/err, next state SHALL be ERR, dropping s_cyc_o.
REQ-027 With WB_G18_ARB_TIMEOUT_EN undefined, no counter SHALL exist and BUSY SHALL wait indefinitely for the slave.

Structure
REQ-028 Shared package wb_g18_pkg SHALL hold the FSM state typedef and the default timeout constant.
REQ-029 The timeout counter SHALL be sub-module wb_g18_wdt (clear, enable, expired), instantiated only under WB_G18_ARB_TIMEOUT_EN.
REQ-030 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-031 m0 read 0x00000100 alone -> s_stb_o at t+1, s_adr_o=0x100, m0_ack_o with slave data 0xDEADBEEF, m1 silent.
REQ-032 m0 and m1 request in the same cycle after reset -> m0 served first, m1 next, with s_cyc_o low for >=1 cycle between transfers.
REQ-033 m1 write with we_i=1 -> m1_err_o=1 for exactly one cycle, s_stb_o never asserted.
REQ-034 Timeout enabled, timeout_cycles=8, slave never acks -> owner err_o at BUSY cycle 8, then IDLE.
REQ-035 Owner drops cyc_i mid-BUSY and the slave acks one cycle later -> no ack reaches either master.
REQ-036 wb_rstn_i=0 asserted during BUSY -> next cycle all outputs 0, then an m1 request is granted cleanly.

Source files
------------

// File: rtl/wb_g18_pkg.sv
// Shared types and constants for the wb_g18 flash-read arbiter.
package wb_g18_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } arb_state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd64;

   function automatic logic timeout_in_range(input int unsigned cycles);
      return (cycles >= 32'd2) && (cycles <= 32'd255);
   endfunction

endpackage

// File: rtl/wb_g18_arb_if.sv
// One Wishbone classic link; master drives the request, slave the termination.
interface wb_g18_arb_if #(
   parameter int unsigned wb_dw = 32,
   parameter int unsigned wb_aw = 32
);
   logic [wb_aw-1:0] adr;
   logic [wb_dw-1:0] dat_w;
   logic [wb_dw-1:0] dat_r;
   logic [3:0]       sel;
   logic             we;
   logic [1:0]       bte;
   logic [2:0]       cti;
   logic             cyc;
   logic             stb;
   logic             ack;
   logic             err;

   modport master (output adr, dat_w, sel, we, bte, cti, cyc, stb,
                   input  ack, err, dat_r);
   modport slave  (input  adr, dat_w, sel, we, bte, cti, cyc, stb,
                   output ack, err, dat_r);
endinterface

// File: rtl/wb_g18_wdt.sv
// Slave-ack watchdog: counts BUSY cycles, flags the last permitted one.
module wb_g18_wdt
   import wb_g18_pkg::*;
#(
   parameter int unsigned timeout_cycles = TIMEOUT_CYCLES_DEF
) (
   input  logic wb_clk_i,
   input  logic wb_rstn_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [7:0] LAST = 8'(timeout_cycles - 32'd1);

   logic [7:0] count_r;

   // clear on BUSY entry has priority over counting
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         count_r <= 8'd0;
      end else if (clear) begin
         count_r <= 8'd0;
      end else if (enable) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LAST);
endmodule

// File: rtl/wb_g18_arb.sv
// Two-master round-robin arbiter in front of a read-only flash slave.
// Define WB_G18_ARB_TIMEOUT_EN to return err when the slave never terminates.
module wb_g18_arb
   import wb_g18_pkg::*;
#(
   parameter int unsigned wb_dw          = 32,
   parameter int unsigned wb_aw          = 32,
   parameter int unsigned timeout_cycles = TIMEOUT_CYCLES_DEF
) (
   input logic           wb_clk_i,
   input logic           wb_rstn_i,
   wb_g18_arb_if.slave   m0,
   wb_g18_arb_if.slave   m1,
   wb_g18_arb_if.master  s
);
   if (!timeout_in_range(timeout_cycles)) begin : g_bad_timeout
      $error("wb_g18_arb: timeout_cycles must be within 2..255");
   end

   arb_state_t       state_r, state_nxt_s;
   logic             owner_r, rr_ptr_r;
   logic             req0_s, req1_s, any_req_s, grant_s, grant_we_s;
   logic             own_req_s, expired_s, fwd_s;
   logic             ack0_s, ack1_s, err0_s, err1_s;
   logic [wb_aw-1:0] own_adr_s;
   logic [wb_dw-1:0] own_dat_s;

   assign req0_s     = m0.cyc & m0.stb;
   assign req1_s     = m1.cyc & m1.stb;
   assign any_req_s  = req0_s | req1_s;
   assign grant_we_s = grant_s ? m1.we : m0.we;
   assign own_req_s  = owner_r ? req1_s : req0_s;

   // pick the winner; a tie goes to the master favoured by rr_ptr
   always_comb begin
      grant_s = 1'b0;
      if (req0_s && req1_s) begin
         grant_s = rr_ptr_r;
      end else if (req1_s) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

`ifdef WB_G18_ARB_TIMEOUT_EN
   logic busy_entry_s;
   assign busy_entry_s = (state_r == ST_IDLE) && (state_nxt_s == ST_BUSY);

   wb_g18_wdt #(.timeout_cycles(timeout_cycles)) u_wdt (
      .wb_clk_i (wb_clk_i),
      .wb_rstn_i(wb_rstn_i),
      .clear    (busy_entry_s),
      .enable   (state_r == ST_BUSY),
      .expired  (expired_s)
   );
`else
   assign expired_s = 1'b0;
`endif

   // state, owner and round-robin pointer registers
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state_r  <= ST_IDLE;
         owner_r  <= 1'b0;
         rr_ptr_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && any_req_s) begin
            owner_r  <= grant_s;
            rr_ptr_r <= ~grant_s;
         end else begin
            owner_r  <= owner_r;
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // next-state: writes are refused via ERR, abandoned cycles go straight back to IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = grant_we_s ? ST_ERR : ST_BUSY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!own_req_s || s.ack || s.err) begin
               state_nxt_s = ST_IDLE;
            end else if (expired_s) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_ERR:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // terminations reach only the owner; err wins if the slave raises both
   always_comb begin
      fwd_s  = wb_rstn_i & (state_r == ST_BUSY) & own_req_s;
      ack0_s = fwd_s & ~owner_r & s.ack & ~s.err;
      ack1_s = fwd_s &  owner_r & s.ack & ~s.err;
      err0_s = ~owner_r & ((fwd_s & s.err) | (wb_rstn_i & (state_r == ST_ERR)));
      err1_s =  owner_r & ((fwd_s & s.err) | (wb_rstn_i & (state_r == ST_ERR)));
   end

   assign own_adr_s = owner_r ? m1.adr   : m0.adr;
   assign own_dat_s = owner_r ? m1.dat_w : m0.dat_w;

   assign s.adr   = own_adr_s;
   assign s.dat_w = own_dat_s;
   assign s.sel   = owner_r ? m1.sel : m0.sel;
   assign s.we    = owner_r ? m1.we  : m0.we;
   assign s.bte   = owner_r ? m1.bte : m0.bte;
   assign s.cti   = owner_r ? m1.cti : m0.cti;
   assign s.cyc   = fwd_s;
   assign s.stb   = fwd_s;

   assign m0.ack   = ack0_s;
   assign m0.err   = err0_s;
   assign m1.ack   = ack1_s;
   assign m1.err   = err1_s;
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;
endmodule

// File: tb/tb_wb_g18_arb.sv
// Bench for wb_g18_arb: directed scenarios, then random traffic against a transfer-level model.
module tb_wb_g18_arb;
`ifdef WB_G18_ARB_TIMEOUT_EN
   localparam int TO = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO = 64;
   localparam bit TO_EN = 1'b0;
`endif

   logic clk;
   logic rstn;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_g18_arb_if #(.wb_dw(32), .wb_aw(32)) m0_if ();
   wb_g18_arb_if #(.wb_dw(32), .wb_aw(32)) m1_if ();
   wb_g18_arb_if #(.wb_dw(32), .wb_aw(32)) s_if ();

   wb_g18_arb #(.wb_dw(32), .wb_aw(32), .timeout_cycles(TO)) dut (
      .wb_clk_i (clk),
      .wb_rstn_i(rstn),
      .m0       (m0_if),
      .m1       (m1_if),
      .s        (s_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus values, applied just after each rising edge
   logic        d_req [2];
   logic        d_we  [2];
   logic [31:0] d_adr [2];
   logic [31:0] d_dat [2];
   logic [3:0]  d_sel [2];
   logic [2:0]  d_cti [2];
   logic [1:0]  d_bte [2];
   logic        d_sack, d_serr, d_rstn;
   logic [31:0] d_sdat;
   bit          auto_slave;

   // transfer-level model: who is being served, and whether an error is owed
   bit x_active, x_errflag;
   int x_owner, x_pref, x_age;
   bit snap_req [2];
   bit snap_we  [2];
   bit snap_ack, snap_err, snap_rstn;
   bit e_ack [2];
   bit e_err [2];
   bit e_scyc;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply();
      rstn        = d_rstn;
      m0_if.cyc   = d_req[0]; m0_if.stb = d_req[0]; m0_if.we  = d_we[0];
      m0_if.adr   = d_adr[0]; m0_if.dat_w = d_dat[0]; m0_if.sel = d_sel[0];
      m0_if.cti   = d_cti[0]; m0_if.bte = d_bte[0];
      m1_if.cyc   = d_req[1]; m1_if.stb = d_req[1]; m1_if.we  = d_we[1];
      m1_if.adr   = d_adr[1]; m1_if.dat_w = d_dat[1]; m1_if.sel = d_sel[1];
      m1_if.cti   = d_cti[1]; m1_if.bte = d_bte[1];
      s_if.ack    = d_sack;   s_if.err = d_serr; s_if.dat_r = d_sdat;
   endtask

   task automatic model_step();
      if (!snap_rstn) begin
         x_active = 1'b0; x_errflag = 1'b0; x_owner = 0; x_pref = 0; x_age = 0;
      end else if (x_errflag) begin
         x_errflag = 1'b0;
      end else if (x_active) begin
         if (!snap_req[x_owner] || snap_ack || snap_err) begin
            x_active = 1'b0;
         end else if (TO_EN && x_age == TO - 1) begin
            x_active = 1'b0;
            x_errflag = 1'b1;
         end else begin
            x_age++;
         end
      end else if (snap_req[0] || snap_req[1]) begin
         int w;
         w = (snap_req[0] && snap_req[1]) ? x_pref : (snap_req[1] ? 1 : 0);
         x_owner = w;
         x_pref = 1 - w;
         if (snap_we[w]) x_errflag = 1'b1;
         else begin x_active = 1'b1; x_age = 0; end
      end
   endtask

   task automatic model_expect();
      bit fwd;
      fwd = d_rstn && x_active && d_req[x_owner];
      e_scyc = fwd;
      for (int n = 0; n < 2; n++) begin
         e_ack[n] = fwd && (x_owner == n) && d_sack && !d_serr;
         e_err[n] = d_rstn && (x_owner == n) && ((fwd && d_serr) || x_errflag);
      end
   endtask

   task automatic compare();
      chk("m0_ack", m0_if.ack, e_ack[0]);
      chk("m0_err", m0_if.err, e_err[0]);
      chk("m1_ack", m1_if.ack, e_ack[1]);
      chk("m1_err", m1_if.err, e_err[1]);
      chk("s_cyc", s_if.cyc, e_scyc);
      chk("s_stb", s_if.stb, e_scyc);
      chk("m0_dat", m0_if.dat_r, d_sdat);
      chk("m1_dat", m1_if.dat_r, d_sdat);
      if (e_scyc) begin
         chk("s_adr", s_if.adr, d_adr[x_owner]);
         chk("s_dat", s_if.dat_w, d_dat[x_owner]);
         chk("s_sel", s_if.sel, d_sel[x_owner]);
         chk("s_we", s_if.we, d_we[x_owner]);
         chk("s_cti", s_if.cti, d_cti[x_owner]);
         chk("s_bte", s_if.bte, d_bte[x_owner]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      apply();
      if (auto_slave) begin
         int r;
         #1;
         r = $urandom_range(0, 11);
         d_sack = (s_if.stb === 1'b1) && (r < 4);
         d_serr = (s_if.stb === 1'b1) && (r == 11);
         d_sdat = $urandom;
         apply();
      end
      @(negedge clk);
      model_expect();
      compare();
      for (int n = 0; n < 2; n++) begin
         snap_req[n] = d_req[n];
         snap_we[n]  = d_we[n];
      end
      snap_ack = d_sack; snap_err = d_serr; snap_rstn = d_rstn;
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         d_req[n] = 1'b0; d_we[n] = 1'b0; d_adr[n] = 32'd0; d_dat[n] = 32'd0;
         d_sel[n] = 4'hF; d_cti[n] = 3'd0; d_bte[n] = 2'd0;
         snap_req[n] = 1'b0; snap_we[n] = 1'b0;
      end
      d_sack = 1'b0; d_serr = 1'b0; d_rstn = 1'b0; d_sdat = 32'd0;
      snap_ack = 1'b0; snap_err = 1'b0; snap_rstn = 1'b0; auto_slave = 1'b0;
      apply();

      tick(); tick();
      chk("rst_s_cyc", s_if.cyc, 1'b0);
      chk("rst_m0_ack", m0_if.ack, 1'b0);
      chk("rst_m1_err", m1_if.err, 1'b0);
      d_rstn = 1'b1; tick();

      // lone m0 read
      d_req[0] = 1'b1; d_adr[0] = 32'h0000_0100;
      tick(); chk("m0rd_stb_t0", s_if.stb, 1'b0);
      tick(); chk("m0rd_stb_t1", s_if.stb, 1'b1); chk("m0rd_adr", s_if.adr, 32'h100);
      chk("m0rd_model_stb", e_scyc, 1'b1);
      d_sack = 1'b1; d_sdat = 32'hDEAD_BEEF;
      tick(); chk("m0rd_ack", m0_if.ack, 1'b1); chk("m0rd_dat", m0_if.dat_r, 32'hDEAD_BEEF);
      chk("m0rd_m1_ack", m1_if.ack, 1'b0); chk("m0rd_model_ack", e_ack[0], 1'b1);
      d_sack = 1'b0; d_req[0] = 1'b0;
      tick(); chk("m0rd_ack_done", m0_if.ack, 1'b0);

      // simultaneous requests after reset: m0 first, gap, then m1
      d_rstn = 1'b0; tick(); d_rstn = 1'b1; tick();
      d_req[0] = 1'b1; d_req[1] = 1'b1; d_adr[0] = 32'h200; d_adr[1] = 32'h300;
      tick(); chk("tie_cyc_t0", s_if.cyc, 1'b0);
      d_sack = 1'b1;
      tick(); chk("tie_first_adr", s_if.adr, 32'h200); chk("tie_m0_ack", m0_if.ack, 1'b1);
      chk("tie_m1_ack_0", m1_if.ack, 1'b0);
      d_sack = 1'b0; d_req[0] = 1'b0;
      tick(); chk("tie_gap", s_if.cyc, 1'b0);
      d_sack = 1'b1;
      tick(); chk("tie_second_adr", s_if.adr, 32'h300); chk("tie_m1_ack", m1_if.ack, 1'b1);
      chk("tie_m0_ack_0", m0_if.ack, 1'b0);
      d_sack = 1'b0; d_req[1] = 1'b0; tick();

      // m1 write is refused with a single err cycle
      d_req[1] = 1'b1; d_we[1] = 1'b1;
      tick(); chk("wr_stb_t0", s_if.stb, 1'b0);
      tick(); chk("wr_m1_err", m1_if.err, 1'b1); chk("wr_stb_t1", s_if.stb, 1'b0);
      chk("wr_m0_err", m0_if.err, 1'b0);
      d_req[1] = 1'b0; d_we[1] = 1'b0;
      tick(); chk("wr_err_once", m1_if.err, 1'b0);

      // owner abandons the cycle; a late ack must not leak
      d_req[0] = 1'b1; d_adr[0] = 32'h400;
      tick(); tick(); chk("abort_stb", s_if.stb, 1'b1);
      d_req[0] = 1'b0; d_sack = 1'b1;
      tick(); chk("abort_cyc", s_if.cyc, 1'b0); chk("abort_m0_ack", m0_if.ack, 1'b0);
      tick(); chk("abort_late_m0", m0_if.ack, 1'b0); chk("abort_late_m1", m1_if.ack, 1'b0);
      d_sack = 1'b0;

      // reset in the middle of a transfer, then a clean m1 grant
      d_req[0] = 1'b1;
      tick(); tick(); chk("rstmid_stb", s_if.stb, 1'b1);
      d_rstn = 1'b0; d_sack = 1'b1;
      tick(); chk("rstmid_cyc", s_if.cyc, 1'b0); chk("rstmid_ack", m0_if.ack, 1'b0);
      d_rstn = 1'b1; d_sack = 1'b0; d_req[0] = 1'b0; d_req[1] = 1'b1; d_adr[1] = 32'h500;
      tick(); chk("rstmid_idle_cyc", s_if.cyc, 1'b0); chk("rstmid_idle_err", m0_if.err, 1'b0);
      d_sack = 1'b1;
      tick(); chk("rstmid_m1_adr", s_if.adr, 32'h500); chk("rstmid_m1_ack", m1_if.ack, 1'b1);
      d_sack = 1'b0; d_req[1] = 1'b0; tick();

`ifdef WB_G18_ARB_TIMEOUT_EN
      // silent slave: eight BUSY cycles, then err to the owner
      d_req[0] = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         tick(); chk("to_busy_stb", s_if.stb, 1'b1);
      end
      tick(); chk("to_m0_err", m0_if.err, 1'b1); chk("to_stb_low", s_if.stb, 1'b0);
      d_req[0] = 1'b0;
      tick(); chk("to_err_once", m0_if.err, 1'b0);
`endif

      // random traffic from both masters against a randomly answering slave
      auto_slave = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (d_req[i]) begin
               if (e_ack[i] || e_err[i] || $urandom_range(0, 31) == 0) d_req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               d_req[i] = 1'b1;
               d_we[i]  = ($urandom_range(0, 5) == 0);
               d_adr[i] = $urandom;
               d_dat[i] = $urandom;
               d_sel[i] = 4'($urandom);
               d_cti[i] = 3'($urandom);
               d_bte[i] = 2'($urandom);
            end
         end
         d_rstn = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
